// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_pkg
//  Purpose  : Shared definitions for the two-port SRAM arbiter. Holds the FSM
//             state encoding, the chip-select decode table, the byte-index
//             width, the legal timing-parameter limits and a byte-scan helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

    localparam int BYTE_IDX_W = 2;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;
    localparam int HOLD_MIN = 1;
    localparam int HOLD_MAX = 3;

    // Cycle counter must reach WAIT_MAX-1 inside a strobe phase.
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    // Active-low one-hot chip select, indexed by word address bits [20:19].
    localparam logic [3:0][3:0] CS_DECODE = {4'h7, 4'hB, 4'hD, 4'hE};

    // Lowest set bit of mask at index >= from; returns 4 when none remains.
    function automatic logic [2:0] first_set(input logic [3:0] mask,
                                             input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) r = 3'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter_if
//  Purpose  : Bundles the two requester ports and the SRAM pad signals.
//             master : requester / SRAM-model side
//             slave  : arbiter side
//  Ports    : pN_req/we/addr/be/wdata -> arbiter, pN_ack/rdata <- arbiter,
//             sram cs_n/read_n/write_n/addr/data/oe <- arbiter,
//             sram data in -> arbiter
//  Revision : 1.0  initial release
// ============================================================================
interface sram_arbiter_if;
    logic        i_p0_req,   i_p1_req;
    logic        i_p0_we,    i_p1_we;
    logic [20:0] i_p0_addr,  i_p1_addr;
    logic [3:0]  i_p0_be,    i_p1_be;
    logic [31:0] i_p0_wdata, i_p1_wdata;
    logic        o_p0_ack,   o_p1_ack;
    logic [31:0] o_p0_rdata, o_p1_rdata;
    logic [3:0]  o_sram_cs_n;
    logic        o_sram_read_n;
    logic        o_sram_write_n;
    logic [20:0] o_sram_addr;
    logic [7:0]  o_sram_data;
    logic        o_sram_data_oe;
    logic [7:0]  i_sram_data;

    modport master (
        output i_p0_req, i_p1_req, i_p0_we, i_p1_we, i_p0_addr, i_p1_addr,
               i_p0_be, i_p1_be, i_p0_wdata, i_p1_wdata, i_sram_data,
        input  o_p0_ack, o_p1_ack, o_p0_rdata, o_p1_rdata, o_sram_cs_n,
               o_sram_read_n, o_sram_write_n, o_sram_addr, o_sram_data,
               o_sram_data_oe
    );

    modport slave (
        input  i_p0_req, i_p1_req, i_p0_we, i_p1_we, i_p0_addr, i_p1_addr,
               i_p0_be, i_p1_be, i_p0_wdata, i_p1_wdata, i_sram_data,
        output o_p0_ack, o_p1_ack, o_p0_rdata, o_p1_rdata, o_sram_cs_n,
               o_sram_read_n, o_sram_write_n, o_sram_addr, o_sram_data,
               o_sram_data_oe
    );
endinterface
`default_nettype wire

// File: rtl/sram_byte_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : sram_byte_cycle
//  Purpose  : Times the STROBE and HOLD phases of one SRAM byte access.
//  Ports    : i_clk, i_reset_n   clock, async active-low reset
//             i_state            current arbiter state
//             o_strobe_end       last STROBE cycle of this byte
//             o_hold_end         last HOLD cycle (byte done)
//  Revision : 1.0  initial release
// ============================================================================
module sram_byte_cycle
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  wire    i_clk,
    input  wire    i_reset_n,
    input  state_t i_state,
    output logic   o_strobe_end,
    output logic   o_hold_end
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter restarts at zero on every phase boundary, so it always
    // reads "cycles already spent in the current phase".
    always_comb begin
        o_strobe_end = (i_state == ST_STROBE) && (cnt_q == CNT_W'(WAIT_CYCLES - 1));
        o_hold_end   = (i_state == ST_HOLD)   && (cnt_q == CNT_W'(HOLD_CYCLES - 1));
        cnt_d        = '0;
        if (((i_state == ST_STROBE) || (i_state == ST_HOLD)) &&
            !o_strobe_end && !o_hold_end) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Two-port arbiter onto an 8-bit asynchronous SRAM (4 chips).
//             32-bit reads are split into four byte accesses; writes touch
//             only enabled bytes. All SRAM-side outputs are registered.
//  Ports    : i_clk, i_reset_n   clock, async active-low reset
//             bus (slave)        requester ports + SRAM pads
//  Config   : SRAM_ARB_FIXED_PRIO_EN defined -> port 0 wins ties;
//             undefined -> round-robin, last-served port loses ties.
//  Revision : 1.0  initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  wire           i_clk,
    input  wire           i_reset_n,
    sram_arbiter_if.slave bus
);

    // Out-of-range parameters are clamped to the nearest legal value.
    localparam int WAIT_EFF = (WAIT_CYCLES < WAIT_MIN) ? WAIT_MIN :
                              (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
    localparam int HOLD_EFF = (HOLD_CYCLES < HOLD_MIN) ? HOLD_MIN :
                              (HOLD_CYCLES > HOLD_MAX) ? HOLD_MAX : HOLD_CYCLES;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;     // 0 = port 0, 1 = port 1
    logic                  last_q, last_d;   // last served port
    logic                  we_q, we_d;
    logic [20:0]           addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;   // bytes to access
    logic [31:0]           wdata_q, wdata_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [31:0]           rbuf_q, rbuf_d;   // read assembly buffer
    logic [3:0]            cs_n_q, cs_n_d;
    logic                  read_n_q, read_n_d;
    logic                  write_n_q, write_n_d;
    logic [20:0]           saddr_q, saddr_d;
    logic [7:0]            sdata_q, sdata_d;
    logic                  oe_q, oe_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [31:0]           rdata0_q, rdata0_d;
    logic [31:0]           rdata1_q, rdata1_d;

    logic                  strobe_end, hold_end;
    logic                  pick;
    logic                  busy;
    logic [2:0]            nxt;

    sram_byte_cycle #(
        .WAIT_CYCLES (WAIT_EFF),
        .HOLD_CYCLES (HOLD_EFF)
    ) u_byte_cycle (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_state      (state_q),
        .o_strobe_end (strobe_end),
        .o_hold_end   (hold_end)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        rbuf_d   = rbuf_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        saddr_d  = saddr_q;
        sdata_d  = sdata_q;
        nxt      = 3'd4;

`ifdef SRAM_ARB_FIXED_PRIO_EN
        pick = !bus.i_p0_req;
`else
        pick = (bus.i_p0_req && bus.i_p1_req) ? !last_q : !bus.i_p0_req;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.i_p0_req || bus.i_p1_req) begin
                    gnt_d   = pick;
                    we_d    = pick ? bus.i_p1_we    : bus.i_p0_we;
                    addr_d  = pick ? bus.i_p1_addr  : bus.i_p0_addr;
                    wdata_d = pick ? bus.i_p1_wdata : bus.i_p0_wdata;
                    mask_d  = !we_d ? 4'hF : (pick ? bus.i_p1_be : bus.i_p0_be);
                    nxt     = first_set(mask_d, 3'd0);
                    if (nxt[2]) begin
                        state_d = ST_ACK;      // empty write: no SRAM cycle
                    end else begin
                        idx_d   = nxt[1:0];
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                if (strobe_end) begin
                    if (!we_q) rbuf_d[{idx_q, 3'b000} +: 8] = bus.i_sram_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_end) begin
                    nxt = first_set(mask_q, {1'b0, idx_q} + 3'd1);
                    if (nxt[2]) begin
                        state_d = ST_ACK;
                        if (!we_q) begin
                            if (gnt_q) rdata1_d = rbuf_q;
                            else       rdata0_d = rbuf_q;
                        end
                    end else begin
                        idx_d   = nxt[1:0];
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_ACK: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Pad outputs are decoded from the next state so they register
        // in lock-step with the state flops.
        busy      = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                    (state_d == ST_HOLD);
        cs_n_d    = busy ? CS_DECODE[addr_d[20:19]] : 4'hF;
        read_n_d  = !((state_d == ST_STROBE) && !we_d);
        write_n_d = !((state_d == ST_STROBE) &&  we_d);
        oe_d      = busy && we_d;
        if (busy) saddr_d = {addr_d[18:0], idx_d};
        if (busy && we_d) sdata_d = wdata_d[{idx_d, 3'b000} +: 8];
        ack0_d    = (state_d == ST_ACK) && !gnt_d;
        ack1_d    = (state_d == ST_ACK) &&  gnt_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;     // port 0 wins the first tie
            we_q      <= 1'b0;
            addr_q    <= '0;
            mask_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            rbuf_q    <= '0;
            cs_n_q    <= 4'hF;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            saddr_q   <= '0;
            sdata_q   <= '0;
            oe_q      <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            rbuf_q    <= rbuf_d;
            cs_n_q    <= cs_n_d;
            read_n_q  <= read_n_d;
            write_n_q <= write_n_d;
            saddr_q   <= saddr_d;
            sdata_q   <= sdata_d;
            oe_q      <= oe_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.o_sram_cs_n    = cs_n_q;
    assign bus.o_sram_read_n  = read_n_q;
    assign bus.o_sram_write_n = write_n_q;
    assign bus.o_sram_addr    = saddr_q;
    assign bus.o_sram_data    = sdata_q;
    assign bus.o_sram_data_oe = oe_q;
    assign bus.o_p0_ack       = ack0_q;
    assign bus.o_p1_ack       = ack1_q;
    assign bus.o_p0_rdata     = rdata0_q;
    assign bus.o_p1_rdata     = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Directed self-checking bench for sram_arbiter. A default
//             instance covers reads, writes, empty writes, reset abort and
//             arbitration; two extra instances cover WAIT_CYCLES = 1 and 15.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sram_arbiter_if bus ();

    sram_arbiter u_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    // SRAM model: returns 0x10 + byte index while read strobe is low.
    assign bus.i_sram_data = !bus.o_sram_read_n ? (8'h10 + {6'd0, bus.o_sram_addr[1:0]}) : 8'h00;

    // ---------------- pad monitor for the main instance ----------------
    int          wr_pulses = 0, rd_pulses = 0, oe_cycles = 0, bad_cycles = 0;
    int          cs_cycles = 0, rd_run = 0, rd_width = 0;
    logic [1:0]  wr_idx  [0:255];
    logic [7:0]  wr_dat  [0:255];
    logic [20:0] rd_addr [0:255];
    logic [3:0]  last_cs = 4'hF;
    logic        prev_wn = 1'b1, prev_rn = 1'b1;

    always @(posedge clk) begin
        #1;
        if (!bus.o_sram_write_n && prev_wn && wr_pulses < 256) begin
            wr_idx[wr_pulses] = bus.o_sram_addr[1:0];
            wr_dat[wr_pulses] = bus.o_sram_data;
            wr_pulses++;
        end
        if (!bus.o_sram_read_n && prev_rn && rd_pulses < 256) begin
            rd_addr[rd_pulses] = bus.o_sram_addr;
            rd_pulses++;
        end
        if (bus.o_sram_data_oe) oe_cycles++;
        if ((bus.o_sram_data_oe && (bus.o_sram_cs_n == 4'hF || !bus.o_sram_read_n)) ||
            (!bus.o_sram_read_n && !bus.o_sram_write_n)) bad_cycles++;
        if (bus.o_sram_cs_n != 4'hF) begin
            cs_cycles++;
            last_cs = bus.o_sram_cs_n;
        end
        if (!bus.o_sram_read_n) rd_run++;
        else begin
            if (rd_run != 0) rd_width = rd_run;
            rd_run = 0;
        end
        prev_wn = bus.o_sram_write_n;
        prev_rn = bus.o_sram_read_n;
    end

    // ---------------- WAIT_CYCLES = 1 / 15 instances ----------------
    logic x_req [2];

    for (genvar g = 0; g < 2; g++) begin : g_wait
        sram_arbiter_if u_if ();
        int run   = 0;
        int width = 0;
        assign u_if.i_p0_req   = x_req[g];
        assign u_if.i_p0_we    = 1'b0;
        assign u_if.i_p0_addr  = 21'h0;
        assign u_if.i_p0_be    = 4'h0;
        assign u_if.i_p0_wdata = 32'h0;
        assign u_if.i_p1_req   = 1'b0;
        assign u_if.i_p1_we    = 1'b0;
        assign u_if.i_p1_addr  = 21'h0;
        assign u_if.i_p1_be    = 4'h0;
        assign u_if.i_p1_wdata = 32'h0;
        assign u_if.i_sram_data = 8'h5A;
        sram_arbiter #(.WAIT_CYCLES((g == 0) ? 1 : 15), .HOLD_CYCLES(1)) u_dut (
            .i_clk     (clk),
            .i_reset_n (rst_n),
            .bus       (u_if)
        );
        always @(posedge clk) begin
            #1;
            if (!u_if.o_sram_read_n) run++;
            else begin
                if (run != 0) width = run;
                run = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request, counts edges until an ack (first edge = 1).
    task automatic run(input logic r0, input logic r1, input logic we,
                       input logic [20:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int lat, output int who,
                       output logic ack_after);
        bus.i_p0_we = we; bus.i_p0_addr = addr; bus.i_p0_be = be; bus.i_p0_wdata = wd;
        bus.i_p1_we = we; bus.i_p1_addr = addr; bus.i_p1_be = be; bus.i_p1_wdata = wd;
        bus.i_p0_req = r0;
        bus.i_p1_req = r1;
        lat = -1; who = -1; ack_after = 1'bx;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (bus.o_p0_ack || bus.o_p1_ack) begin
                lat = n;
                who = bus.o_p0_ack ? 0 : 1;
                break;
            end
        end
        bus.i_p0_req = 1'b0;
        bus.i_p1_req = 1'b0;
        tick();
        ack_after = bus.o_p0_ack | bus.o_p1_ack;
        tick();
    endtask

    task automatic xrun(input int g, output int lat, output int width);
        x_req[g] = 1'b1;
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if ((g == 0) ? g_wait[0].u_if.o_p0_ack : g_wait[1].u_if.o_p0_ack) begin
                lat = n;
                break;
            end
        end
        x_req[g] = 1'b0;
        repeat (2) tick();
        width = (g == 0) ? g_wait[0].width : g_wait[1].width;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   lat, who, base, cs_base, oe_base, bad_base, hit;
        logic ack_after;
        int   exp_who [4];
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_who = '{0, 0, 0, 0};
`else
        exp_who = '{0, 1, 0, 1};
`endif
        bus.i_p0_req = 0; bus.i_p0_we = 0; bus.i_p0_addr = 0; bus.i_p0_be = 0; bus.i_p0_wdata = 0;
        bus.i_p1_req = 0; bus.i_p1_we = 0; bus.i_p1_addr = 0; bus.i_p1_be = 0; bus.i_p1_wdata = 0;
        x_req[0] = 0; x_req[1] = 0;

        // Reset values
        repeat (3) tick();
        check("rst_cs_n",    64'(bus.o_sram_cs_n),    64'hF);
        check("rst_read_n",  64'(bus.o_sram_read_n),  64'h1);
        check("rst_write_n", 64'(bus.o_sram_write_n), 64'h1);
        check("rst_addr",    64'(bus.o_sram_addr),    64'h0);
        check("rst_oe",      64'(bus.o_sram_data_oe), 64'h0);
        check("rst_acks",    64'({bus.o_p0_ack, bus.o_p1_ack}), 64'h0);
        check("rst_rdata",   64'({bus.o_p0_rdata, bus.o_p1_rdata}), 64'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Port 0 read, chip 1, word 3
        base = rd_pulses;
        run(1, 0, 0, 21'h080003, 4'h0, 32'h0, lat, who, ack_after);
        check("rd_latency",   64'(lat), 64'd17);
        check("rd_port",      64'(who), 64'd0);
        check("rd_ack_pulse", 64'(ack_after), 64'h0);
        check("rd_rdata",     64'(bus.o_p0_rdata), 64'h13121110);
        check("rd_cs_n",      64'(last_cs), 64'hD);
        check("rd_strobes",   64'(rd_pulses - base), 64'd4);
        check("rd_addr_b0",   64'(rd_addr[base]), 64'h00000C);
        check("rd_addr_b3",   64'(rd_addr[base + 3]), 64'h00000F);
        check("rd_width",     64'(rd_width), 64'd2);

        // Port 1 write, be=1010
        base = wr_pulses; oe_base = oe_cycles; bad_base = bad_cycles;
        run(0, 1, 1, 21'h100005, 4'b1010, 32'hAABBCCDD, lat, who, ack_after);
        check("wr_latency",  64'(lat), 64'd9);
        check("wr_port",     64'(who), 64'd1);
        check("wr_pulses",   64'(wr_pulses - base), 64'd2);
        check("wr_idx0",     64'(wr_idx[base]), 64'd1);
        check("wr_dat0",     64'(wr_dat[base]), 64'hCC);
        check("wr_idx1",     64'(wr_idx[base + 1]), 64'd3);
        check("wr_dat1",     64'(wr_dat[base + 1]), 64'hAA);
        check("wr_oe_cycles", 64'(oe_cycles - oe_base), 64'd8);
        check("wr_oe_bad",   64'(bad_cycles - bad_base), 64'd0);
        check("rdata_hold",  64'(bus.o_p0_rdata), 64'h13121110);

        // Empty write
        cs_base = cs_cycles;
        run(1, 0, 1, 21'h180001, 4'b0000, 32'h12345678, lat, who, ack_after);
        check("be0_latency", 64'(lat), 64'd1);
        check("be0_cs_idle", 64'(cs_cycles - cs_base), 64'd0);

        // Reset during STROBE of byte 2
        bus.i_p0_we = 1; bus.i_p0_addr = 21'h000010; bus.i_p0_be = 4'hF; bus.i_p0_wdata = 32'h44332211;
        bus.i_p0_req = 1;
        hit = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (!bus.o_sram_write_n && bus.o_sram_addr[1:0] == 2'd2) begin
                hit = 1;
                break;
            end
        end
        check("abort_reached", 64'(hit), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_write_n", 64'(bus.o_sram_write_n), 64'h1);
        check("abort_cs_n",    64'(bus.o_sram_cs_n),    64'hF);
        check("abort_oe",      64'(bus.o_sram_data_oe), 64'h0);
        bus.i_p0_req = 0;
        repeat (3) tick();
        check("abort_no_ack",  64'({bus.o_p0_ack, bus.o_p1_ack}), 64'h0);
        rst_n = 1'b1;
        repeat (2) tick();
        run(0, 1, 0, 21'h000000, 4'h0, 32'h0, lat, who, ack_after);
        check("post_rst_latency", 64'(lat), 64'd17);
        check("post_rst_port",    64'(who), 64'd1);
        check("post_rst_rdata",   64'(bus.o_p1_rdata), 64'h13121110);

        // Simultaneous requests, repeated
        for (int r = 0; r < 4; r++) begin
            run(1, 1, 0, 21'h000002, 4'h0, 32'h0, lat, who, ack_after);
            check($sformatf("tie_round%0d", r), 64'(who), 64'(exp_who[r]));
        end
        check("no_double_strobe", 64'(bad_cycles), 64'd0);

        // Timing parameter extremes
        xrun(0, lat, hit);
        check("w1_latency", 64'(lat), 64'd13);
        check("w1_width",   64'(hit), 64'd1);
        xrun(1, lat, hit);
        check("w15_latency", 64'(lat), 64'd69);
        check("w15_width",   64'(hit), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, strobe-low duration in clocks, legal range 1..15.
REQ-002 Parameter: HOLD_CYCLES, 1, strobe-high cycles before the next byte, legal range 1..3.
REQ-003 Clocking: one clock, i_clk; reset is i_reset_n, asynchronous, active-low.
REQ-004 i_clk  in  1  system clock.
REQ-005 i_reset_n  in  1  async active-low reset.
REQ-006 i_pN_req  in  1  port N (N=0,1) request; held until ack.
REQ-007 i_pN_we  in  1  1 = write, 0 = read.
REQ-008 i_pN_addr  in  21  word address: [20:19] selects chip, [18:0] selects word.
REQ-009 i_pN_be  in  4  write byte enables; ignored on reads.
REQ-010 i_pN_wdata  in  32  write data.
REQ-011 o_pN_ack  out  1  one-cycle completion pulse.
REQ-012 o_pN_rdata  out  32  read data.
REQ-013 o_sram_cs_n  out  4  chip selects, active-low.
REQ-014 o_sram_read_n / o_sram_write_n  out  1 each  strobes, active-low.
REQ-015 o_sram_addr  out  21  byte address {word[18:0], byte[1:0]}.
REQ-016 o_sram_data, o_sram_data_oe  out  8, 1  write data and tristate enable.
REQ-017 i_sram_data  in  8  read data from pad.

Function
REQ-018 FSM states: IDLE, SETUP, STROBE, HOLD, ACK.
REQ-019 Arbitration happens only in IDLE; the grant is held until ACK, and there is no preemption.
REQ-020 IDLE->SETUP when any request is present. In SETUP (1 cycle): address valid, one-hot cs_n low, both strobes high.
REQ-021 STROBE lasts WAIT_CYCLES, with read_n or write_n low. HOLD lasts HOLD_CYCLES, with strobes high and cs_n still low.
REQ-022 After HOLD: the FSM goes to SETUP if bytes remain, otherwise to ACK. ACK pulses o_pN_ack for 1 cycle, then returns to IDLE.
REQ-023 Reads always access all 4 bytes, index 0..3, little-endian: byte k goes to rdata[8k+7:8k].
REQ-024 Read data is sampled on the clock edge that ends the last STROBE cycle.
REQ-025 Writes perform cycles only for bytes with be=1, in ascending order.
REQ-026 A write with be=4'b0000 goes IDLE->ACK with no SRAM activity.
REQ-027 Read ack latency is 1+4*(1+WAIT_CYCLES+HOLD_CYCLES) cycles after the IDLE cycle that sampled the request; this is 17 with the defaults.
REQ-028 o_sram_data_oe is high from SETUP through HOLD of write bytes only, and is never high during reads.
REQ-029 o_pN_rdata updates only on read completion and holds otherwise.
REQ-030 If the request is deasserted mid-transaction, the transaction still completes and the ack still pulses.
REQ-031 All SRAM-side outputs are registered and glitch-free.
REQ-032 At most one strobe is low in any cycle.

Reset
REQ-033 Asserting i_reset_n low immediately forces IDLE, aborting any transfer, including in the middle of STROBE.
REQ-034 Reset values: cs_n=4'hF; read_n=1; write_n=1; addr=0; data=0; oe=0; acks=0; rdata=0; round-robin pointer favours port 0.

Configuration
REQ-035 Macro SRAM_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests.
REQ-036 Macro SRAM_ARB_FIXED_PRIO_EN undefined: round-robin; the last-served port loses ties, and the pointer updates at ACK.

Structure
REQ-037 Shared package sram_arb_pkg holds:
- state encoding constants
- chip-select decode constant table
- byte-index width
- WAIT_CYCLES/HOLD_CYCLES legal limits
REQ-038 One sub-module, sram_byte_cycle, is natural: it times SETUP/STROBE/HOLD for one byte and signals done. The arbiter handles grant, byte sequencing and data assembly.

Verification
REQ-039 Port 0 reads addr 21'h080003 with SRAM model returning 8'h10..8'h13: cs_n=4'hD, sram addr 21'h00000C..F, rdata=32'h13121110, ack at cycle 17.
REQ-040 Port 1 writes be=4'b1010, wdata=32'hAABBCCDD: exactly two write_n pulses, bytes 8'hCC at index 1 and 8'hAA at index 3; oe never high outside those.
REQ-041 Both ports request reads in the same cycle, repeatedly: grants alternate 0,1,0,1 without the macro, and stay 0,0,0 with SRAM_ARB_FIXED_PRIO_EN.
REQ-042 Write with be=4'b0000: ack 1 cycle after grant, with cs_n staying 4'hF throughout.
REQ-043 i_reset_n low during STROBE of byte 2: write_n high, cs_n=4'hF, oe=0 immediately; no ack; a fresh request after reset completes normally.
REQ-044 WAIT_CYCLES=1 and WAIT_CYCLES=15: strobe widths equal the parameter, and read latency matches REQ-027.
